// File: rtl/noc_pkg.sv
// Shared NoC definitions: mesh direction indices, default port count and the
// wormhole lock state used by the switch allocator.
package noc_pkg;

  localparam int DIR_E = 0;
  localparam int DIR_W = 1;
  localparam int DIR_N = 2;
  localparam int DIR_S = 3;
  localparam int DIR_L = 4;

  localparam int NUM_PORTS_DEF = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
// The pointer register belongs to the instantiating module.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found_s;
  int   pos_s;

  // Scan N positions starting at the pointer and keep the first requester.
  always_comb begin
    gnt_o   = {N{1'b0}};
    idx_o   = {IDX_W{1'b0}};
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < N; k++) begin
      pos_s = (int'(ptr_i) + k) % N;
      if (!found_s && req_i[pos_s]) begin
        found_s      = 1'b1;
        gnt_o[pos_s] = 1'b1;
        idx_o        = IDX_W'(pos_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/switch_alloc_rr.sv
// Round-robin switch allocator with registered grants. Define
// SWITCH_ALLOC_WORMHOLE_LOCK_EN to hold an output for one packet until its tail.
module switch_alloc_rr #(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS_DEF,
  parameter int DIR_W     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       in_req,
  input  logic [NUM_PORTS*DIR_W-1:0] in_dir,
  input  logic [NUM_PORTS-1:0]       in_tail,
  input  logic [NUM_PORTS-1:0]       out_en,
  output logic [NUM_PORTS-1:0]       st_req,
  output logic [NUM_PORTS-1:0]       in_ack,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [NUM_PORTS*DIR_W-1:0] out_sel
);

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_col_s;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] elig_s;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] win_gnt_s;
  logic [NUM_PORTS-1:0][DIR_W-1:0]     win_idx_s;
  logic [NUM_PORTS-1:0]                grant_s;
  logic [NUM_PORTS-1:0]                locked_s;

  logic [NUM_PORTS-1:0][DIR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_PORTS-1:0][DIR_W-1:0]     sel_q, sel_d;
  logic [NUM_PORTS-1:0]                ack_q, ack_d;
  logic [NUM_PORTS-1:0]                valid_q, valid_d;

`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
  noc_pkg::lock_state_t                lock_q [NUM_PORTS];
  logic [NUM_PORTS-1:0][DIR_W-1:0]     owner_q;
`else
  logic                                unused_tail_s;
  assign unused_tail_s = ^in_tail;
`endif

  // Column o of the request matrix: inputs whose in-range direction targets o.
  always_comb begin
    req_col_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (in_req[i] && (in_dir[i*DIR_W +: DIR_W] == DIR_W'(o))) begin
          req_col_s[o][i] = 1'b1;
        end else begin
          req_col_s[o][i] = 1'b0;
        end
      end
    end
  end

  // Route-compute hint, independent of credits and masked during reset.
  always_comb begin
    st_req = {NUM_PORTS{1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (reset) begin
        st_req[o] = 1'b0;
      end else begin
        st_req[o] = |req_col_s[o];
      end
    end
  end

  // A locked output only sees its owner's request.
  always_comb begin
    elig_s   = req_col_s;
    locked_s = {NUM_PORTS{1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
      if (lock_q[o] == noc_pkg::LOCKED) begin
        locked_s[o] = 1'b1;
        elig_s[o]   = req_col_s[o] & (NUM_PORTS'(1) << owner_q[o]);
      end else begin
        locked_s[o] = 1'b0;
      end
`endif
      grant_s[o] = out_en[o] & (|elig_s[o]);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter #(
      .N     (NUM_PORTS),
      .IDX_W (DIR_W)
    ) u_arb (
      .req_i (elig_s[g]),
      .ptr_i (ptr_q[g]),
      .gnt_o (win_gnt_s[g]),
      .idx_o (win_idx_s[g])
    );
  end

  // Next grant outputs and pointers; the pointer is frozen while locked.
  always_comb begin
    ack_d   = {NUM_PORTS{1'b0}};
    valid_d = grant_s;
    sel_d   = '0;
    ptr_d   = ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (grant_s[o]) begin
        ack_d    = ack_d | win_gnt_s[o];
        sel_d[o] = win_idx_s[o];
        if (locked_s[o]) begin
          ptr_d[o] = ptr_q[o];
        end else if (win_idx_s[o] == DIR_W'(NUM_PORTS - 1)) begin
          ptr_d[o] = {DIR_W{1'b0}};
        end else begin
          ptr_d[o] = win_idx_s[o] + DIR_W'(1);
        end
      end else begin
        sel_d[o] = {DIR_W{1'b0}};
      end
    end
  end

  // Registered grants, pointers and (optionally) per-output lock FSMs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= {NUM_PORTS{1'b0}};
      valid_q <= {NUM_PORTS{1'b0}};
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
      owner_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        lock_q[o] <= noc_pkg::IDLE;
      end
`endif
    end else begin
      ack_q   <= ack_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (lock_q[o])
          noc_pkg::IDLE: begin
            if (grant_s[o] && !in_tail[win_idx_s[o]]) begin
              lock_q[o]  <= noc_pkg::LOCKED;
              owner_q[o] <= win_idx_s[o];
            end
          end
          noc_pkg::LOCKED: begin
            if (grant_s[o] && in_tail[owner_q[o]]) begin
              lock_q[o] <= noc_pkg::IDLE;
            end
          end
          default: lock_q[o] <= noc_pkg::IDLE;
        endcase
      end
`endif
    end
  end

  assign in_ack    = ack_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;

endmodule

// File: doc/switch_alloc_rr.md
Name: switch_alloc_rr

Overview:
- Parametrised switch allocator for the mesh router.
- Each input port presents a request with a desired output direction; each output port picks one requesting input per cycle.
- Arbitration is round-robin per output, with registered grants that drive the input ack and the crossbar select.
- Generalises the fixed-priority, 5-port switch-traversal control to N ports with fairness.
- Supports optional wormhole locking of an output to one packet.

Parameters:
- NUM_PORTS, 5, number of input ports and output ports (square crossbar); index 0=E, 1=W, 2=N, 3=S, 4=Local/eject, further indices are extra local ports.
- DIR_W, 3, width of one direction/select field; must satisfy 2**DIR_W >= NUM_PORTS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_req  in  NUM_PORTS  input i has a flit with a VC allocated and requests traversal
- in_dir  in  NUM_PORTS*DIR_W  requested output of input i, in field [i*DIR_W +: DIR_W]
- in_tail  in  NUM_PORTS  flit at input i is a tail flit; used only with the optional feature
- out_en  in  NUM_PORTS  output o can accept a flit this cycle (credit available)
- st_req  out  NUM_PORTS  combinational: at least one valid request targets output o
- in_ack  out  NUM_PORTS  registered: input i won traversal
- out_valid  out  NUM_PORTS  registered: output o carries a granted flit
- out_sel  out  NUM_PORTS*DIR_W  registered: winning input index for output o (crossbar select)

Behaviour:
- Clock is clk. reset is synchronous, active-high.
- Reset values:
  - in_ack=0, out_valid=0, out_sel=0.
  - All round-robin pointers=0.
  - All lock states IDLE.
  - st_req forced to 0 while reset=1.
- Valid request: req[i][o] = in_req[i] && in_dir[i]==o && in_dir[i] < NUM_PORTS. An out-of-range in_dir produces no request and no ack, and is never an error.
- st_req[o] = OR over i of req[i][o]. It is independent of out_en.
- Arbitration, per output o, evaluated each cycle only when out_en[o]=1:
  - The winner is the first requester scanning from ptr[o] upward, modulo NUM_PORTS.
  - With no requester or out_en[o]=0: no grant, and the pointer holds.
- Pointer update: on a grant, ptr[o] <= winner+1, wrapping to 0 after NUM_PORTS-1.
- Latency: the request is sampled at edge k; in_ack, out_valid and out_sel are valid in the cycle after edge k and last exactly one cycle per grant.
- An input requests exactly one output, so at most one in_ack per input per cycle. Distinct outputs arbitrate independently in the same cycle.
- A held request with out_en=1 is re-arbitrated every cycle. Back-to-back grants to the same input are allowed when it is the sole requester.
- A U-turn (in_dir==i) is legal and is arbitrated normally.
- Reset asserted mid-operation clears all registered outputs and pointers at that edge. No grant from the reset cycle appears afterwards.

Optional Feature:
- Macro SWITCH_ALLOC_WORMHOLE_LOCK_EN.
- Defined:
  - Each output has a 2-state FSM, IDLE and LOCKED, plus an owner register of DIR_W bits.
  - IDLE->LOCKED when a flit is granted with in_tail[winner]=0; owner <= winner.
  - In LOCKED, only owner's request is eligible; other requesters get no grant even when out_en=1. The pointer does not move.
  - LOCKED->IDLE when owner is granted with in_tail=1.
  - A single-flit packet (head with in_tail=1) never locks.
  - out_en=0 while LOCKED holds the lock.
- Undefined: in_tail is ignored, no lock state exists, and every cycle arbitrates freely.

Decomposition:
- Shared package noc_pkg holds:
  - direction constants DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3, DIR_L=4;
  - a default port-count constant;
  - lock FSM state enum lock_state_t {IDLE, LOCKED}.
- One sub-module, rr_arbiter: a NUM_PORTS-wide request vector plus pointer in, one-hot grant plus encoded index out. It is combinational, and the pointer register lives in the parent.
- The parent instantiates one rr_arbiter per output via generate.

Test Plan:
- Reset: assert reset with all in_req=1 -> st_req=0; in_ack, out_valid, out_sel all 0 on the following cycle.
- Single request: in_req[2]=1, in_dir[2]=4, out_en[4]=1 -> st_req[4]=1 same cycle; next cycle in_ack[2]=1, out_valid[4]=1, out_sel[4]=2.
- Fairness: inputs 0, 1, 3 all request output 2 with out_en[2]=1 for 6 cycles -> grants in order 0,1,3,0,1,3. out_en[2]=0 for one cycle -> no grant and the pointer holds.
- Parallel and invalid: in_dir[0]=1, in_dir[1]=0, in_dir[3]=7, all requesting with out_en all 1 -> in_ack[0] and in_ack[1] together, in_ack[3] never, st_req only bits 0 and 1.
- Lock (macro defined): input 0 sends head, body, tail to output 3 while input 4 also requests output 3 -> input 4 is acked only in the cycle after input 0's tail grant. Without the macro the two alternate.
- Mid-run reset: reset during contention -> pointers return to 0; the first grant after reset goes to the lowest-index requester.
